// File: rtl/router_reg.sv
//======================================================================
// router_reg : 1x3 router datapath register stage (header latch, full
//              holding byte, parity accumulate/check, FIFO write data).
// Optional: define ROUTER_REG_ERR_CNT_EN to add the saturating err_cnt.
// Revision: 1.0
//======================================================================
`default_nettype none

module router_reg #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  rst_int_reg,
  output logic                  parity_done,
  output logic                  low_pkt_valid,
  output logic                  err,
`ifdef ROUTER_REG_ERR_CNT_EN
  output logic [7:0]            err_cnt,
`endif
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_hdr_reg;
  logic [DATA_WIDTH-1:0] r_ff_byte;
  logic [DATA_WIDTH-1:0] r_int_parity;
  logic [DATA_WIDTH-1:0] r_pkt_parity;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_parity_done;
  logic                  r_low_pkt_valid;
  logic                  r_err;

  logic w_hdr_load;
  logic w_pd_set;
  logic w_unused_full_state;

  // FIFO_FULL_STATE needs no datapath action; the byte is already parked.
  assign w_unused_full_state = full_state;

  assign w_hdr_load = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign w_pd_set   = (ld_state && !fifo_full && !pkt_valid) ||
                      (laf_state && r_low_pkt_valid && !r_parity_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr_reg <= '0;
      r_ff_byte <= '0;
      r_dout    <= '0;
    end else begin
      if (w_hdr_load)
        r_hdr_reg <= data_in;
      if (ld_state && fifo_full)
        r_ff_byte <= data_in;
      if (lfd_state)
        r_dout <= r_hdr_reg;
      else if (ld_state && !fifo_full)
        r_dout <= data_in;
      else if (laf_state)
        r_dout <= r_ff_byte;
    end
  end

  // Payload bytes accumulate even when the FIFO is full; the parity byte never does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_int_parity <= '0;
      r_pkt_parity <= '0;
    end else begin
      if (detect_add)
        r_int_parity <= '0;
      else if (lfd_state)
        r_int_parity <= r_int_parity ^ r_hdr_reg;
      else if (ld_state && pkt_valid)
        r_int_parity <= r_int_parity ^ data_in;
      if (ld_state && !pkt_valid)
        r_pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_low_pkt_valid <= 1'b0;
      r_parity_done   <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      if (rst_int_reg)
        r_low_pkt_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
        r_low_pkt_valid <= 1'b1;

      if (detect_add)
        r_parity_done <= 1'b0;
      else if (w_pd_set)
        r_parity_done <= 1'b1;

      if (lfd_state)
        r_err <= 1'b0;
      else if (rst_int_reg && r_parity_done)
        r_err <= (r_int_parity != r_pkt_parity);
    end
  end

`ifdef ROUTER_REG_ERR_CNT_EN
  logic       r_err_d;
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_d   <= 1'b0;
      r_err_cnt <= 8'h00;
    end else begin
      r_err_d <= r_err;
      if (r_err && !r_err_d && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'h01;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign dout          = r_dout;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;

endmodule

`default_nettype wire
